// File: rtl/sram_mem_responder.sv
// MEM-stage responder: one 32-bit word access as two 16-bit async SRAM cycles plus wait states.
// Define SRAM_MEM_RESPONDER_RANGE_CHECK_EN to reject out-of-window addresses with addr_err.
module sram_mem_responder #(
   parameter int ADDR_OFFSET     = 1024,
   parameter int SRAM_ADDR_WIDTH = 18,
   parameter int WAIT_CYCLES     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic [31:0]                address,
   input  logic [31:0]                write_data,
   output logic [31:0]                read_data,
   output logic                       ready,
   output logic                       addr_err,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [15:0]                sram_dq_out,
   output logic                       sram_dq_oe,
   input  logic [15:0]                sram_dq_in,
   output logic                       sram_we_n,
   output logic                       sram_oe_n,
   output logic [2:0]                 fsm_state
);

   localparam int WW = SRAM_ADDR_WIDTH - 1;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] WAIT_LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

   // Handshake: ready=0 while a request is present and the access has not reached DONE;
   // the pipeline freezes on ~ready and advances on the DONE edge.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACC_LO = 3'd1,
      S_ACC_HI = 3'd2,
      S_WAIT   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            state, state_d;
   logic [CW-1:0]     wait_cnt, wait_cnt_d;
   logic              op_wr;
   logic [WW-1:0]     word_q;
   logic [15:0]       wdata_hi;
   logic              req;
   logic [WW-1:0]     word_in;
   logic              out_of_range;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr_d;
   logic [15:0]       sram_dq_out_d;
   logic              we_n_d, oe_n_d, dq_oe_d, addr_err_d;

   assign req       = rd_en | wr_en;
   assign word_in   = WW'((address - 32'(ADDR_OFFSET)) >> 2);
   assign ready     = ~req | (state == S_DONE);
   assign fsm_state = state;

`ifdef SRAM_MEM_RESPONDER_RANGE_CHECK_EN
   assign out_of_range = (address < 32'(ADDR_OFFSET)) ||
                         (((address - 32'(ADDR_OFFSET)) >> (WW + 2)) != 32'd0);
`else
   assign out_of_range = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_d;
         wait_cnt <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state;
      wait_cnt_d = wait_cnt;
      unique case (state)
         S_IDLE: begin
            if (req) state_d = out_of_range ? S_DONE : S_ACC_LO;
         end
         S_ACC_LO: state_d = S_ACC_HI;
         S_ACC_HI: begin
            if (WAIT_CYCLES == 0) begin
               state_d = S_DONE;
            end else begin
               state_d    = S_WAIT;
               wait_cnt_d = '0;
            end
         end
         S_WAIT: begin
            if (wait_cnt == WAIT_LAST) state_d = S_DONE;
            else wait_cnt_d = wait_cnt + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pad controls are registered from the state being entered, so a reset edge
   // releases the strobes on that same edge.
   always_comb begin
      sram_addr_d   = sram_addr;
      sram_dq_out_d = sram_dq_out;
      we_n_d        = 1'b1;
      oe_n_d        = 1'b1;
      dq_oe_d       = 1'b0;
      addr_err_d    = (state == S_IDLE) && req && out_of_range;
      if (state_d == S_ACC_LO) begin
         sram_addr_d = {word_in, 1'b0};
         if (wr_en) sram_dq_out_d = write_data[15:0];
         we_n_d  = ~wr_en;
         oe_n_d  = wr_en;
         dq_oe_d = wr_en;
      end else if (state_d == S_ACC_HI) begin
         sram_addr_d = {word_q, 1'b1};
         if (op_wr) sram_dq_out_d = wdata_hi;
         we_n_d  = ~op_wr;
         oe_n_d  = op_wr;
         dq_oe_d = op_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_wr       <= 1'b0;
         word_q      <= '0;
         wdata_hi    <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         addr_err    <= 1'b0;
      end else begin
         sram_addr   <= sram_addr_d;
         sram_dq_out <= sram_dq_out_d;
         sram_dq_oe  <= dq_oe_d;
         sram_we_n   <= we_n_d;
         sram_oe_n   <= oe_n_d;
         addr_err    <= addr_err_d;
         // A simultaneous rd_en/wr_en is treated as a write.
         if (state == S_IDLE && req) begin
            op_wr    <= wr_en;
            word_q   <= word_in;
            wdata_hi <= write_data[31:16];
            if (out_of_range && !wr_en) read_data <= '0;
         end
         if (state == S_ACC_LO && !op_wr) read_data[15:0]  <= sram_dq_in;
         if (state == S_ACC_HI && !op_wr) read_data[31:16] <= sram_dq_in;
      end
   end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: directed vector table, random word traffic against a
// word-level memory model, and hand sequences for reset/abort and back-to-back timing.
`timescale 1ns/1ps
module tb_sram_mem_responder;

`ifdef SRAM_MEM_RESPONDER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, write_data, read_data;
   logic        ready, addr_err;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n, sram_oe_n;
   logic [2:0]  fsm_state;

   logic        wr_en0, rd_en0;
   logic [31:0] address0, write_data0, read_data0;
   logic        ready0, addr_err0;
   logic [17:0] sram_addr0;
   logic [15:0] sram_dq_out0, sram_dq_in0;
   logic        sram_dq_oe0, sram_we_n0, sram_oe_n0;
   logic [2:0]  fsm_state0;

   sram_mem_responder #(.ADDR_OFFSET(1024), .SRAM_ADDR_WIDTH(18), .WAIT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready), .addr_err(addr_err),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
      .fsm_state(fsm_state));

   sram_mem_responder #(.ADDR_OFFSET(1024), .SRAM_ADDR_WIDTH(18), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
      .write_data(write_data0), .read_data(read_data0), .ready(ready0), .addr_err(addr_err0),
      .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
      .sram_dq_in(sram_dq_in0), .sram_we_n(sram_we_n0), .sram_oe_n(sram_oe_n0),
      .fsm_state(fsm_state0));

   // Asynchronous SRAM pads: write on a clock edge with we_n low and pads driven.
   bit [15:0] mem  [0:262143];
   bit [15:0] mem0 [0:262143];
   assign sram_dq_in  = sram_oe_n  ? 16'h0 : mem[sram_addr];
   assign sram_dq_in0 = sram_oe_n0 ? 16'h0 : mem0[sram_addr0];
   always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
   always @(posedge clk) if (!sram_we_n0 && sram_dq_oe0) mem0[sram_addr0] <= sram_dq_out0;

   int checks = 0;
   int failures = 0;

   // Word-level reference: SRAM word index -> 32-bit value, plus last loaded value.
   bit [31:0] ref_mem [int];
   logic [31:0] last_rd;

   typedef struct {
      int          low, we, oe, dqoe, err;
      logic [17:0] a_lo, a_hi;
      logic [15:0] d_lo, d_hi;
      logic [31:0] rdata;
      logic        err_done;
      logic        timeout;
   } res_t;

   typedef struct {
      bit          wr;
      bit          rd;
      logic [31:0] a;
      logic [31:0] d;
      logic [17:0] lo;
      logic [31:0] exp_rd;
      bit          oor;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      logic [31:0] t;
      t = (a - 32'd1024) >> 2;
      return int'(t & 32'h1FFFF);
   endfunction

   function automatic logic [31:0] ref_read(input int w);
      if (ref_mem.exists(w)) return ref_mem[w];
      return 32'h0;
   endfunction

   task automatic run_access(input bit wr, input bit rd, input logic [31:0] a,
                             input logic [31:0] d, output res_t r);
      int  nstrobe;
      bit  done;
      r.low = 0; r.we = 0; r.oe = 0; r.dqoe = 0; r.err = 0;
      r.a_lo = '0; r.a_hi = '0; r.d_lo = '0; r.d_hi = '0;
      r.rdata = '0; r.err_done = 1'b0; r.timeout = 1'b1;
      nstrobe = 0;
      done = 1'b0;
      wr_en = wr; rd_en = rd; address = a; write_data = d;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready) begin
            r.rdata = read_data;
            r.err_done = addr_err;
            r.timeout = 1'b0;
            done = 1'b1;
         end else begin
            r.low++;
            if (addr_err) r.err++;
         end
         if (!sram_we_n || !sram_oe_n) begin
            nstrobe++;
            if (nstrobe == 1) begin r.a_lo = sram_addr; r.d_lo = sram_dq_out; end
            else begin r.a_hi = sram_addr; r.d_hi = sram_dq_out; end
         end
         if (!sram_we_n) r.we++;
         if (!sram_oe_n) r.oe++;
         if (sram_dq_oe) r.dqoe++;
         @(posedge clk); #1;
         if (done) break;
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic check_access(input string tag, input bit wr, input bit oor,
                               input logic [17:0] lo, input logic [31:0] d,
                               input logic [31:0] exp_rd, input res_t r);
      chk({tag, "_timeout"}, {31'd0, r.timeout}, 32'd0);
      chk({tag, "_ready_low"}, r.low, oor ? 32'd1 : 32'd7);
      chk({tag, "_we_cycles"}, r.we, (wr && !oor) ? 32'd2 : 32'd0);
      chk({tag, "_oe_cycles"}, r.oe, (!wr && !oor) ? 32'd2 : 32'd0);
      chk({tag, "_dqoe_cycles"}, r.dqoe, (wr && !oor) ? 32'd2 : 32'd0);
      chk({tag, "_err_busy"}, r.err, 32'd0);
      chk({tag, "_err_done"}, {31'd0, r.err_done}, {31'd0, oor});
      chk({tag, "_rdata"}, r.rdata, exp_rd);
      if (!oor) begin
         chk({tag, "_addr_lo"}, {14'd0, r.a_lo}, {14'd0, lo});
         chk({tag, "_addr_hi"}, {14'd0, r.a_hi}, {14'd0, lo + 18'd1});
      end
      if (wr && !oor) begin
         chk({tag, "_dq_lo"}, {16'd0, r.d_lo}, {16'd0, d[15:0]});
         chk({tag, "_dq_hi"}, {16'd0, r.d_hi}, {16'd0, d[31:16]});
      end
   endtask

   task automatic wait_ready0(output int low, output bit to);
      low = 0;
      to = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ready0) begin to = 1'b0; break; end
         low++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      res_t        r;
      logic [31:0] exp;
      logic [31:0] a, d;
      int          w, op, low, ocnt;
      bit          to;

      vecs[0]  = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 18'd2,       32'h0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'd1028,   32'h0,        18'd2,       32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'd1024,   32'h12345678, 18'd0,       32'h0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'd1031,   32'h0,        18'd2,       32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 32'd2000,   32'hCAFEF00D, 18'h001E8,   32'h0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'd2000,   32'h0,        18'h001E8,   32'hCAFEF00D, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'd525308, 32'hA5A55A5A, 18'h3FFFE,   32'h0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'd525308, 32'h0,        18'h3FFFE,   32'hA5A55A5A, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'd525312, 32'h0,        18'd0,
                   RC ? 32'h0 : 32'h12345678, RC};
      vecs[9]  = '{1'b1, 1'b0, 32'd16,     32'h77777777, 18'h3FE08,   32'h0, RC};
      vecs[10] = '{1'b0, 1'b1, 32'd16,     32'h0,        18'h3FE08,
                   RC ? 32'h0 : 32'h77777777, RC};
      vecs[11] = '{1'b0, 1'b1, 32'd1020,   32'h0,        18'h3FFFE,
                   RC ? 32'h0 : 32'hA5A55A5A, RC};
      vecs[12] = '{1'b0, 1'b1, 32'd1024,   32'h0,        18'd0,       32'h12345678, 1'b0};

      // Reset held for two edges with a write pending.
      rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0; address = 32'd1028; write_data = 32'hFFFFFFFF;
      wr_en0 = 1'b0; rd_en0 = 1'b0; address0 = '0; write_data0 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_read_data", read_data, 32'h0);
      chk("rst_sram_addr", {14'd0, sram_addr}, 32'h0);
      chk("rst_dq_out", {16'd0, sram_dq_out}, 32'h0);
      chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
      chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; wr_en = 1'b0;
      last_rd = 32'h0;
      @(posedge clk); #1;

      // Directed vectors.
      for (int i = 0; i < 13; i++) begin
         run_access(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, r);
         exp = vecs[i].wr ? last_rd : vecs[i].exp_rd;
         check_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].oor, vecs[i].lo,
                      vecs[i].d, exp, r);
         if (vecs[i].wr && !vecs[i].oor) ref_mem[widx(vecs[i].a)] = vecs[i].d;
         if (!vecs[i].wr) last_rd = exp;
      end

      // Random traffic within a small window of words.
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         w  = $urandom_range(0, 15);
         a  = 32'd1024 + 32'(4 * w) + 32'($urandom_range(0, 3));
         d  = $urandom;
         run_access(op != 0, op != 1, a, d, r);
         if (op != 0) begin
            check_access($sformatf("rnd%0d", i), 1'b1, 1'b0, 18'(2 * w), d, last_rd, r);
            ref_mem[w] = d;
         end else begin
            exp = ref_read(w);
            check_access($sformatf("rnd%0d", i), 1'b0, 1'b0, 18'(2 * w), d, exp, r);
            last_rd = exp;
         end
      end

      // Read with rd_en dropped during the high half still completes.
      run_access(1'b0, 1'b1, 32'd1104, 32'h0, r);
      check_access("prime", 1'b0, 1'b0, 18'd40, 32'h0, 32'h0, r);
      exp = ref_read(1);
      ocnt = 0;
      rd_en = 1'b1; address = 32'd1028;
      for (int c = 1; c <= 8; c++) begin
         if (c == 3) rd_en = 1'b0;
         @(negedge clk);
         if (!sram_oe_n) ocnt++;
         if (c == 8) begin
            chk("drop_done_state", {29'd0, fsm_state}, 32'd4);
            chk("drop_rdata", read_data, exp);
         end
         @(posedge clk); #1;
      end
      chk("drop_oe_cycles", ocnt, 32'd2);
      @(negedge clk);
      chk("drop_back_idle", {29'd0, fsm_state}, 32'd0);
      last_rd = exp;
      @(posedge clk); #1;

      // Reset in the wait phase of a write.
      wr_en = 1'b1; address = 32'd1036; write_data = 32'h11112222;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("midwait_state", {29'd0, fsm_state}, 32'd3);
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midwait_rst_state", {29'd0, fsm_state}, 32'd0);
      chk("midwait_rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("midwait_rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
      chk("midwait_rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("midwait_rst_addr", {14'd0, sram_addr}, 32'd0);
      chk("midwait_rst_rdata", read_data, 32'd0);
      chk("midwait_rst_ready", {31'd0, ready}, 32'd0);
      ref_mem[widx(32'd1036)] = 32'h11112222;
      last_rd = 32'h0;
      @(posedge clk); #1;
      rst = 1'b1; wr_en = 1'b0;
      @(posedge clk); #1;

      // Reset while the low half of a write is on the pads.
      wr_en = 1'b1; address = 32'd1040; write_data = 32'h33334444;
      @(posedge clk); #1;
      @(negedge clk);
      chk("lo_rst_we_before", {31'd0, sram_we_n}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("lo_rst_we_after", {31'd0, sram_we_n}, 32'd1);
      chk("lo_rst_dq_oe_after", {31'd0, sram_dq_oe}, 32'd0);
      chk("lo_rst_addr_after", {14'd0, sram_addr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; wr_en = 1'b0;
      @(posedge clk); #1;

      run_access(1'b0, 1'b1, 32'd1036, 32'h0, r);
      check_access("after_rst_read", 1'b0, 1'b0, 18'd6, 32'h0, 32'h11112222, r);

      // Back-to-back write then read with no wait states, request held across DONE.
      wr_en0 = 1'b1; address0 = 32'd1028; write_data0 = 32'h600DCAFE;
      wait_ready0(low, to);
      chk("b2b_wr_timeout", {31'd0, to}, 32'd0);
      chk("b2b_wr_low", low, 32'd3);
      @(posedge clk); #1;
      wr_en0 = 1'b0; rd_en0 = 1'b1;
      wait_ready0(low, to);
      chk("b2b_rd_timeout", {31'd0, to}, 32'd0);
      chk("b2b_rd_low", low, 32'd3);
      chk("b2b_rd_data", read_data0, 32'h600DCAFE);
      @(posedge clk); #1;
      rd_en0 = 1'b0;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
